// File: rtl/fi_campaign_ctrl.sv
// Fault-injection campaign controller: one-entry word buffer in front of the
// 72-bit injector, tagging words for corruption against a latched budget/interval.
module fi_campaign_ctrl #(
   parameter int WIDTH = 72,
   parameter int CNT_W = 16,
   parameter int GAP_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [1:0]       cfg_mode,
   input  logic [CNT_W-1:0] cfg_count,
   input  logic [GAP_W-1:0] cfg_interval,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic [WIDTH-1:0] fi_word,
   output logic [1:0]       fi_control,
   input  logic [WIDTH-1:0] fi_result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_injected,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] inj_count
);

   // Handshake: a word moves on any cycle where valid && ready; the buffer
   // can take a new word while it drains the held one in the same cycle.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic               full_q, full_d;
   logic               tag_q, tag_d;
   logic [WIDTH-1:0]   word_q, word_d;
   logic [1:0]         mode_q, mode_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [GAP_W-1:0]   interval_q, interval_d;
   logic [CNT_W-1:0]   inj_q, inj_d;
   logic [GAP_W-1:0]   gap_q, gap_d;

   logic               ready_c;
   logic               accept;
   logic               drain;
   logic               tag_now;

   always_comb begin
      state_d    = state_q;
      full_d     = full_q;
      tag_d      = tag_q;
      word_d     = word_q;
      mode_d     = mode_q;
      count_d    = count_q;
      interval_d = interval_q;
      inj_d      = inj_q;
      gap_d      = gap_q;
      tag_now    = 1'b0;

      ready_c = !full_q || out_ready;
      accept  = in_valid && ready_c;
      drain   = full_q && out_ready;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               mode_d     = cfg_mode;
               count_d    = cfg_count;
               interval_d = cfg_interval;
               inj_d      = '0;
               gap_d      = '0;
               if (cfg_mode == 2'b00 || cfg_count == '0) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            // Only accepted words advance the interval; an abort blocks new tags.
            if (accept) begin
               if (!abort && gap_q == interval_q && inj_q < count_q) begin
                  tag_now = 1'b1;
                  inj_d   = inj_q + CNT_W'(1);
                  gap_d   = '0;
               end else if (gap_q != {GAP_W{1'b1}}) begin
                  gap_d = gap_q + GAP_W'(1);
               end
            end
            if (abort || (inj_q == count_q && !(full_q && tag_q))) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (accept) begin
         full_d = 1'b1;
         word_d = in_data;
         tag_d  = tag_now;
      end else if (drain) begin
         full_d = 1'b0;
         tag_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         full_q     <= 1'b0;
         tag_q      <= 1'b0;
         word_q     <= '0;
         mode_q     <= 2'b00;
         count_q    <= '0;
         interval_q <= '0;
         inj_q      <= '0;
         gap_q      <= '0;
      end else begin
         state_q    <= state_d;
         full_q     <= full_d;
         tag_q      <= tag_d;
         word_q     <= word_d;
         mode_q     <= mode_d;
         count_q    <= count_d;
         interval_q <= interval_d;
         inj_q      <= inj_d;
         gap_q      <= gap_d;
      end
   end

   assign in_ready     = ready_c;
   assign out_valid    = full_q;
   assign fi_word      = word_q;
   assign fi_control   = tag_q ? mode_q : 2'b00;
   assign out_injected = tag_q;
   assign out_data     = fi_result;
   assign busy         = (state_q == ST_RUN);
   assign done         = (state_q == ST_DONE);
   assign inj_count    = inj_q;

endmodule

// File: tb/tb_fi_campaign_ctrl.sv
// Bench for fi_campaign_ctrl: table-driven campaigns, hand-written corner
// sequences and random traffic checked against a word-index reference model.
module tb_fi_campaign_ctrl;

   localparam int WIDTH = 72;
   localparam int CNT_W = 16;
   localparam int GAP_W = 8;
   localparam int P_IDLE = 0;
   localparam int P_RUN  = 1;
   localparam int P_DONE = 2;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic             abort;
   logic [1:0]       cfg_mode;
   logic [CNT_W-1:0] cfg_count;
   logic [GAP_W-1:0] cfg_interval;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [WIDTH-1:0] fi_word;
   logic [1:0]       fi_control;
   logic [WIDTH-1:0] fi_result;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_injected;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] inj_count;

   int checks = 0;
   int errors = 0;

   fi_campaign_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .cfg_mode(cfg_mode), .cfg_count(cfg_count), .cfg_interval(cfg_interval),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .fi_word(fi_word), .fi_control(fi_control), .fi_result(fi_result),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_injected(out_injected), .busy(busy), .done(done), .inj_count(inj_count)
   );

   // Stand-in injector: single flip on bit 0, double flip on bits 1:0, "random" flip on bit 71.
   function automatic logic [WIDTH-1:0] inj_mask(input logic [1:0] c);
      case (c)
         2'b01:   return 72'h1;
         2'b10:   return 72'h3;
         2'b11:   return {1'b1, 71'b0};
         default: return '0;
      endcase
   endfunction

   assign fi_result = fi_word ^ inj_mask(fi_control);

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- check helpers ----------------
   task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model / scoreboard ----------------
   logic [WIDTH:0] exp_q[$];   // {tag, data} of words accepted but not yet delivered
   bit             tag_log[$]; // tag of every delivered word, in order
   int             done_cnt = 0;
   int             m_phase = P_IDLE;
   logic [1:0]     m_mode = 2'b00;
   int             m_count = 0;
   int             m_interval = 0;
   int             m_inj = 0;
   int             m_widx = 0;

   logic [WIDTH:0] m_head;
   logic [1:0]     m_ctrl;
   bit             m_full, m_ready, m_accept, m_drain, m_tag, m_pend;
   int             m_next;

   task automatic model_reset();
      exp_q.delete();
      m_phase    = P_IDLE;
      m_mode     = 2'b00;
      m_count    = 0;
      m_interval = 0;
      m_inj      = 0;
      m_widx     = 0;
   endtask

   // Compare on the falling edge, then advance the model across the next rising edge.
   always @(negedge clk) begin
      if (rst_n) begin
         m_full  = (exp_q.size() != 0);
         m_ready = !m_full || out_ready;
         chk("in_ready", in_ready, m_ready);
         chk("out_valid", out_valid, m_full);
         chk("busy", busy, m_phase == P_RUN);
         chk("done", done, m_phase == P_DONE);
         chk_int("inj_count", int'(inj_count), m_inj);
         m_head = '0;
         if (m_full) begin
            m_head = exp_q[0];
            m_ctrl = m_head[WIDTH] ? m_mode : 2'b00;
            chk("out_data", out_data, m_head[WIDTH-1:0] ^ inj_mask(m_ctrl));
            chk("out_injected", out_injected, m_head[WIDTH]);
            chk("fi_control", fi_control, m_ctrl);
         end
         if (done) done_cnt++;

         m_pend   = m_full && m_head[WIDTH];
         m_accept = in_valid && m_ready;
         m_drain  = m_full && out_ready;
         m_tag    = 1'b0;
         // Word n of a campaign (0-based) is injected when it completes a period of
         // interval+1 words and the budget is not yet used up.
         if (m_accept && m_phase == P_RUN && !abort &&
             (m_widx % (m_interval + 1)) == m_interval &&
             (m_widx / (m_interval + 1)) < m_count) begin
            m_tag = 1'b1;
         end
         if (m_accept && m_phase == P_RUN) m_widx++;

         m_next = m_phase;
         case (m_phase)
            P_IDLE: if (start) begin
               m_mode     = cfg_mode;
               m_count    = int'(cfg_count);
               m_interval = int'(cfg_interval);
               m_inj      = 0;
               m_widx     = 0;
               m_next     = (cfg_mode == 2'b00 || cfg_count == 0) ? P_DONE : P_RUN;
            end
            P_RUN: if (abort || (m_inj == m_count && !m_pend)) m_next = P_DONE;
            default: m_next = P_IDLE;
         endcase
         m_phase = m_next;

         if (m_drain) begin
            tag_log.push_back(m_head[WIDTH]);
            void'(exp_q.pop_front());
         end
         if (m_accept) exp_q.push_back({m_tag, in_data});
         if (m_tag) m_inj++;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [WIDTH-1:0] rnd_word();
      logic [95:0] r;
      r = {$urandom(), $urandom(), $urandom()};
      return r[WIDTH-1:0];
   endfunction

   task automatic start_campaign(input logic [1:0] mode, input int count, input int interval);
      cfg_mode     = mode;
      cfg_count    = CNT_W'(count);
      cfg_interval = GAP_W'(interval);
      start        = 1'b1;
      tick();
      start        = 1'b0;
   endtask

   task automatic send_words(input int n);
      for (int w = 0; w < n; w++) begin
         in_valid = 1'b1;
         in_data  = rnd_word();
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while ((busy || done || out_valid) && n < 100) begin
         tick();
         n++;
      end
      if (busy || done || out_valid) begin
         checks++;
         errors++;
         $display("FAIL %s timeout busy=%0b done=%0b out_valid=%0b", name, busy, done, out_valid);
      end
   endtask

   // ---------------- campaign table ----------------
   typedef struct {
      logic [1:0]  mode;
      int          count;
      int          interval;
      int          nwords;
      logic [15:0] exp_tags;   // bit w set: word w is delivered injected
      int          exp_inj;
      int          exp_done;
   } vec_t;

   vec_t vecs[5];

   logic [WIDTH-1:0] d0, d1;
   int               lb, db;

   initial begin
      vecs[0] = '{mode: 2'b01, count: 3, interval: 0, nwords: 5, exp_tags: 16'b0000_0111, exp_inj: 3, exp_done: 1};
      vecs[1] = '{mode: 2'b10, count: 2, interval: 2, nwords: 8, exp_tags: 16'b0010_0100, exp_inj: 2, exp_done: 1};
      vecs[2] = '{mode: 2'b11, count: 2, interval: 1, nwords: 6, exp_tags: 16'b0000_1010, exp_inj: 2, exp_done: 1};
      vecs[3] = '{mode: 2'b11, count: 0, interval: 0, nwords: 4, exp_tags: 16'b0000_0000, exp_inj: 0, exp_done: 1};
      vecs[4] = '{mode: 2'b00, count: 5, interval: 0, nwords: 4, exp_tags: 16'b0000_0000, exp_inj: 0, exp_done: 1};

      rst_n = 1'b0; start = 1'b0; abort = 1'b0;
      cfg_mode = 2'b00; cfg_count = '0; cfg_interval = '0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      #12;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_fi_word", fi_word, '0);
      chk("rst_fi_control", fi_control, 2'b00);
      chk("rst_out_injected", out_injected, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_inj_count", inj_count, '0);
      rst_n = 1'b1;
      tick();

      // IDLE pass-through, one cycle latency
      in_valid = 1'b1; in_data = 72'h1;
      tick();
      in_valid = 1'b0;
      chk("pass_valid", out_valid, 1'b1);
      chk("pass_data", out_data, 72'h1);
      chk("pass_ctrl", fi_control, 2'b00);
      chk("pass_inj", out_injected, 1'b0);
      tick();

      for (int v = 0; v < 5; v++) begin
         wait_idle("vec_idle");
         lb = tag_log.size();
         db = done_cnt;
         out_ready = 1'b1;
         start_campaign(vecs[v].mode, vecs[v].count, vecs[v].interval);
         send_words(vecs[v].nwords);
         repeat (6) tick();
         chk_int("vec_nwords", tag_log.size() - lb, vecs[v].nwords);
         for (int w = 0; w < vecs[v].nwords; w++) begin
            if (lb + w < tag_log.size()) chk("vec_tag", tag_log[lb + w], vecs[v].exp_tags[w]);
         end
         chk_int("vec_done_pulses", done_cnt - db, vecs[v].exp_done);
         chk_int("vec_inj_count", int'(inj_count), vecs[v].exp_inj);
         chk("vec_busy_end", busy, 1'b0);
      end

      // Backpressure with a tagged word held
      wait_idle("bp_idle");
      lb = tag_log.size();
      start_campaign(2'b01, 1, 0);
      out_ready = 1'b0;
      d0 = rnd_word();
      d1 = rnd_word();
      in_valid = 1'b1; in_data = d0;
      tick();
      in_data = d1;
      for (int c = 0; c < 4; c++) begin
         chk("bp_in_ready", in_ready, 1'b0);
         chk("bp_out_data", out_data, d0 ^ 72'h1);
         chk("bp_fi_control", fi_control, 2'b01);
         chk("bp_injected", out_injected, 1'b1);
         chk("bp_inj_count", inj_count, 16'd1);
         tick();
      end
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("bp_second_data", out_data, d1);
      chk("bp_second_inj", out_injected, 1'b0);
      repeat (4) tick();
      chk_int("bp_delivered", tag_log.size() - lb, 2);
      chk("bp_inj_final", inj_count, 16'd1);

      // Abort after the first of four injections
      wait_idle("abort_idle");
      lb = tag_log.size();
      db = done_cnt;
      start_campaign(2'b11, 4, 1);
      send_words(2);
      tick();
      chk("abort_pre_inj", inj_count, 16'd1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      send_words(3);
      repeat (6) tick();
      chk_int("abort_done_pulses", done_cnt - db, 1);
      chk("abort_inj_count", inj_count, 16'd1);
      chk_int("abort_delivered", tag_log.size() - lb, 5);
      if (tag_log.size() >= lb + 5) begin
         chk("abort_tag_w2", tag_log[lb + 1], 1'b1);
         for (int w = 2; w < 5; w++) chk("abort_tag_after", tag_log[lb + w], 1'b0);
      end

      // count=0 finishes on the next cycle without tagging
      wait_idle("zero_idle");
      lb = tag_log.size();
      start_campaign(2'b01, 0, 0);
      chk("zero_done", done, 1'b1);
      chk("zero_busy", busy, 1'b0);
      send_words(2);
      repeat (3) tick();
      chk("zero_done_after", done, 1'b0);
      if (tag_log.size() >= lb + 2) begin
         chk("zero_tag0", tag_log[lb], 1'b0);
         chk("zero_tag1", tag_log[lb + 1], 1'b0);
      end

      // Asynchronous reset mid-campaign with a tagged word held
      wait_idle("rst_idle");
      start_campaign(2'b01, 5, 0);
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = rnd_word();
      tick();
      in_valid = 1'b0;
      chk("mid_busy", busy, 1'b1);
      chk("mid_inj", inj_count, 16'd1);
      chk("mid_valid", out_valid, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", out_valid, 1'b0);
      chk("arst_busy", busy, 1'b0);
      chk("arst_inj_count", inj_count, '0);
      chk("arst_fi_control", fi_control, 2'b00);
      model_reset();
      rst_n = 1'b1;
      out_ready = 1'b1;
      tick();

      // Random traffic against the reference model
      for (int c = 0; c < 2000; c++) begin
         in_valid     = ($urandom_range(0, 3) != 0);
         in_data      = rnd_word();
         out_ready    = ($urandom_range(0, 3) != 0);
         start        = ($urandom_range(0, 11) == 0);
         abort        = ($urandom_range(0, 40) == 0);
         cfg_mode     = 2'($urandom_range(0, 3));
         cfg_count    = CNT_W'($urandom_range(0, 5));
         cfg_interval = GAP_W'($urandom_range(0, 3));
         tick();
      end
      start = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      wait_idle("rand_idle");
      chk_int("rand_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fi_campaign_ctrl.md
Name: fi_campaign_ctrl

Overview:
Sequences the 72-bit fault injector (64 data + 8 SECDED check bits) during ECC cache fault campaigns. It buffers the encoded word stream in a one-entry pipeline register and decides which words are corrupted and with which injector mode. It also counts injections against a programmed budget and signals campaign completion. It sits between the ECC encoder output and the cache data-array write port, and drives the injector's IN/control and forwards its OUT.

Parameters:
WIDTH, 72, codeword width (data + check bits)
CNT_W, 16, width of injection budget and injection counter
GAP_W, 8, width of inter-injection interval

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; launches campaign from IDLE
abort  input  1  one-cycle pulse; terminates campaign
cfg_mode  input  2  injector mode for campaign: 01 single flip, 10 double flip, 11 random flip
cfg_count  input  CNT_W  number of injections in campaign
cfg_interval  input  GAP_W  clean words between consecutive injections
in_valid  input  1  upstream word valid
in_ready  output  1  controller can accept word
in_data  input  WIDTH  encoded word from ECC encoder
fi_word  output  WIDTH  held word, to injector IN
fi_control  output  2  to injector control; 00 = no injection
fi_result  input  WIDTH  injector OUT (combinational from fi_word/fi_control)
out_valid  output  1  downstream word valid
out_ready  input  1  downstream accepts word
out_data  output  WIDTH  word to cache array (= fi_result)
out_injected  output  1  held word carries an injection
busy  output  1  campaign in RUN
done  output  1  one-cycle pulse at campaign end
inj_count  output  CNT_W  injections issued in current/last campaign

Behaviour:
- Reset (async, rst_n=0): state IDLE; buffer empty; out_valid=0, in_ready=1, fi_word=0, fi_control=00, out_injected=0, busy=0, done=0, inj_count=0, gap counter=0. Any held word is dropped.
- Buffer: one entry. in_ready = !full || out_ready. Accept on in_valid&&in_ready; registered, so latency is 1 cycle in_data -> out_data. Simultaneous accept and drain in the same cycle sustain 1 word/cycle. out_valid=full. out_data must hold stable while out_valid && !out_ready.
- fi_word = held word. fi_control = tag ? mode_latched : 00. out_injected = tag. The tag is set at accept time and travels with the word.
- FSM IDLE/RUN/DONE:
  - IDLE: words pass through untagged. start latches cfg_mode, cfg_count and cfg_interval; clears inj_count and the gap counter. If the latched mode=00 or count=0 -> DONE, else -> RUN.
  - RUN: busy=1. On each accept: if gap==interval_latched and inj_count<count_latched, tag the word, inj_count++, gap=0; else gap++ (saturating). interval=0 injects every word. When inj_count==count_latched and the buffer holds no tagged word -> DONE.
  - abort in RUN -> DONE next cycle. An already-tagged held word is still delivered with its tag. No further tagging occurs.
  - DONE: done=1 for exactly one cycle, then IDLE. inj_count holds until the next start.
- start while in RUN or DONE is ignored. start and abort in the same IDLE cycle: start wins, abort is ignored.
- The cfg_* inputs are sampled only at start; changing them in RUN has no effect.
- Upstream stall (in_valid=0) does not advance the gap counter.

Test Plan:
- Reset then pass-through in IDLE: in_data=72'h0..01 with out_ready=1 -> out_data equals in_data one cycle later, fi_control=00, out_injected=0.
- start, mode=01, count=3, interval=0, 5 back-to-back words -> first 3 words have fi_control=01 and out_injected=1; last 2 have 00; done pulses once after word 3 drains; inj_count=3.
- start, mode=10, count=2, interval=2, 8 words -> words 3 and 6 tagged with 10; busy falls after word 6 leaves.
- Backpressure: out_ready=0 for 4 cycles with a tagged word held -> out_data/fi_control stable, in_ready=0, no word lost; injection count unchanged.
- abort after first of count=4 injections (mode=11) -> done pulse, inj_count=1, later words untagged; start with count=0 -> done next cycle, no tags.
- Assert rst_n=0 mid-RUN with a word held -> out_valid=0, busy=0, inj_count=0 immediately, without waiting for a clock edge.
